// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and data memory, with lw/sw hazard handling.
// Build with STORE_BUF_FWD_EN defined for store-to-load forwarding; otherwise matching loads stall.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         st_valid_i,
  input  logic [ADDR_W-1:0]            st_addr_i,
  input  logic [DATA_W-1:0]            st_data_i,
  output logic                         st_ready_o,
  input  logic                         ld_valid_i,
  input  logic [ADDR_W-1:0]            ld_addr_i,
  output logic                         ld_hit_o,
  output logic [DATA_W-1:0]            ld_data_o,
  output logic                         ld_stall_o,
  output logic                         mem_write_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic match, mem_free, push, pop;
`ifdef STORE_BUF_FWD_EN
  logic [DATA_W-1:0] match_data;
`endif

  // Loads compare at word granularity, so the byte-offset bits never take part.
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr_i[1:0];

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    match = 1'b0;
`ifdef STORE_BUF_FWD_EN
    match_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_valid_i && (CNT_W'(i) < count_q) &&
          (addr_q[head_q + PTR_W'(i)][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2])) begin
        match = 1'b1;
`ifdef STORE_BUF_FWD_EN
        match_data = data_q[head_q + PTR_W'(i)];
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign ld_hit_o   = match;
  assign ld_data_o  = match_data;
  assign ld_stall_o = 1'b0;
`else
  assign ld_hit_o   = 1'b0;
  assign ld_data_o  = '0;
  assign ld_stall_o = match;
`endif

  // Store handshake: a store transfers on a rising edge where st_valid_i && st_ready_o;
  // st_ready_o depends only on occupancy, and the producer holds its request until it transfers.
  assign st_ready_o  = (count_q != CNT_W'(DEPTH));
  assign mem_free    = !ld_valid_i || ld_hit_o || ld_stall_o;
  assign mem_write_o = (count_q != '0) && mem_free;
  assign mem_addr_o  = addr_q[head_q];
  assign mem_data_o  = data_q[head_q];
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);

  assign push = st_valid_i && st_ready_o;
  assign pop  = mem_write_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (push) begin
      addr_d[tail_q] = st_addr_i;
      data_d[tail_q] = st_data_i;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model, directed scenarios, random traffic.
// Expectations follow the STORE_BUF_FWD_EN build setting.
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int E_W    = ADDR_W + DATA_W;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              st_valid_i;
  logic [ADDR_W-1:0] st_addr_i;
  logic [DATA_W-1:0] st_data_i;
  logic              st_ready_o;
  logic              ld_valid_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic              ld_hit_o;
  logic [DATA_W-1:0] ld_data_o;
  logic              ld_stall_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [CNT_W-1:0]  count_o;
  logic              empty_o;

  // clock / reset
  always #5 clk_i = ~clk_i;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_ready_o(st_ready_o),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i),
    .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o), .ld_stall_o(ld_stall_o),
    .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  // scoreboard: pending stores oldest-first, plus the log of memory writes seen
  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] wlog[$];
  logic           exp_wr, exp_ready;
  int             n_checks = 0;
  int             n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    logic m;
`ifdef STORE_BUF_FWD_EN
    logic [DATA_W-1:0] fd;
    fd = '0;
`endif
    n = exp_q.size();
    m = 1'b0;
    if (ld_valid_i) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (exp_q[i][E_W-1:DATA_W+2] == ld_addr_i[ADDR_W-1:2]) begin
          m = 1'b1;
`ifdef STORE_BUF_FWD_EN
          fd = exp_q[i][DATA_W-1:0];
`endif
          break;
        end
      end
    end
    exp_wr    = (n != 0) && (!ld_valid_i || m);
    exp_ready = (n != DEPTH);
    chk("count", 64'(count_o), 64'(n));
    chk("empty", 64'(empty_o), 64'(n == 0));
    chk("st_ready", 64'(st_ready_o), 64'(exp_ready));
    chk("mem_write", 64'(mem_write_o), 64'(exp_wr));
    if (exp_wr) begin
      chk("mem_addr", 64'(mem_addr_o), 64'(exp_q[0][E_W-1:DATA_W]));
      chk("mem_data", 64'(mem_data_o), 64'(exp_q[0][DATA_W-1:0]));
    end
`ifdef STORE_BUF_FWD_EN
    chk("ld_hit", 64'(ld_hit_o), 64'(m));
    chk("ld_data", 64'(ld_data_o), 64'(fd));
    chk("ld_stall", 64'(ld_stall_o), 64'(0));
`else
    chk("ld_hit", 64'(ld_hit_o), 64'(0));
    chk("ld_data", 64'(ld_data_o), 64'(0));
    chk("ld_stall", 64'(ld_stall_o), 64'(m));
`endif
  endtask

  // driver tasks: drive just after a falling edge, check, then advance the model at the rising edge
  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    st_valid_i = sv;
    st_addr_i  = sa;
    st_data_i  = sd;
    ld_valid_i = lv;
    ld_addr_i  = la;
    #1;
    check_outputs();
    if (mem_write_o && !rst_i) wlog.push_back({mem_addr_o, mem_data_o});
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (exp_wr) void'(exp_q.pop_front());
      if (st_valid_i && exp_ready) exp_q.push_back({st_addr_i, st_data_i});
    end
    @(negedge clk_i);
  endtask

  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic lv, input logic [31:0] la);
    drive(sv, sa, sd, lv, la);
    tick();
  endtask

  initial begin
    logic        pv;
    logic [31:0] pa, pd, la, ea, ed;
    logic        lv;

    rst_i = 1'b1; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0;
    ld_valid_i = 1'b0; ld_addr_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    // reset state
    chk("rst_st_ready", 64'(st_ready_o), 64'(1));
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_count", 64'(count_o), 64'(0));
    chk("rst_mem_write", 64'(mem_write_o), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    chk("rst_mem_data", 64'(mem_data_o), 64'(0));
    chk("rst_ld_hit", 64'(ld_hit_o), 64'(0));
    chk("rst_ld_data", 64'(ld_data_o), 64'(0));
    chk("rst_ld_stall", 64'(ld_stall_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    step(0, 0, 0, 0, 0);

    // back-to-back stores, no loads
    wlog.delete();
    step(1, 32'h10, 32'hAAAA0001, 0, 0);
    drive(1, 32'h14, 32'hAAAA0002, 0, 0);
    chk("b2b_first_drain", 64'(mem_write_o), 64'(1));
    tick();
    repeat (3) step(0, 0, 0, 0, 0);
    chk("b2b_nwrites", 64'(wlog.size()), 64'(2));
    chk("b2b_wr0", 64'(wlog[0]), {32'h10, 32'hAAAA0001});
    chk("b2b_wr1", 64'(wlog[1]), {32'h14, 32'hAAAA0002});
    chk("b2b_count", 64'(count_o), 64'(0));

    // fill while a missing load owns the memory port
    wlog.delete();
    for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(4 * i), 32'hB0 + 32'(i), 1, 32'h40);
    drive(1, 32'h110, 32'hB5, 1, 32'h40);
    chk("full_count", 64'(count_o), 64'(4));
    chk("full_ready", 64'(st_ready_o), 64'(0));
    chk("full_no_drain", 64'(mem_write_o), 64'(0));
    tick();
    drive(1, 32'h110, 32'hB5, 0, 0);
    chk("full_pop_ready", 64'(st_ready_o), 64'(0));
    tick();
    drive(1, 32'h110, 32'hB5, 0, 0);
    chk("full_accept", 64'(st_ready_o), 64'(1));
    tick();
    repeat (6) step(0, 0, 0, 0, 0);
    chk("full_nwrites", 64'(wlog.size()), 64'(5));
    for (int i = 0; i < 4; i++) begin
      ea = 32'h100 + 32'(4 * i);
      ed = 32'hB0 + 32'(i);
      chk("full_order", 64'(wlog[i]), {ea, ed});
    end
    chk("full_fifth", 64'(wlog[4]), {32'h110, 32'hB5});

    // same-address stores then a load of that word
    wlog.delete();
    step(1, 32'h20, 32'h11111111, 1, 32'h40);
    step(1, 32'h20, 32'h22222222, 1, 32'h40);
`ifdef STORE_BUF_FWD_EN
    drive(0, 0, 0, 1, 32'h20);
    chk("fwd_hit", 64'(ld_hit_o), 64'(1));
    chk("fwd_data", 64'(ld_data_o), 64'(32'h22222222));
    chk("fwd_drain", 64'(mem_write_o), 64'(1));
    tick();
    drive(0, 0, 0, 1, 32'h22);
    chk("fwd_word_hit", 64'(ld_hit_o), 64'(1));
    chk("fwd_word_data", 64'(ld_data_o), 64'(32'h22222222));
    tick();
    drive(0, 0, 0, 1, 32'h22);
    chk("fwd_miss_empty", 64'(ld_hit_o), 64'(0));
    tick();
`else
    drive(0, 0, 0, 1, 32'h20);
    chk("stall_c1", 64'(ld_stall_o), 64'(1));
    chk("stall_drain", 64'(mem_write_o), 64'(1));
    tick();
    drive(0, 0, 0, 1, 32'h20);
    chk("stall_c2", 64'(ld_stall_o), 64'(1));
    tick();
    drive(0, 0, 0, 1, 32'h20);
    chk("stall_release", 64'(ld_stall_o), 64'(0));
    tick();
`endif
    step(0, 0, 0, 0, 0);
    chk("same_addr_nwrites", 64'(wlog.size()), 64'(2));
    chk("same_addr_last", 64'(wlog[wlog.size() - 1]), {32'h20, 32'h22222222});

    // asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) step(1, 32'h200 + 32'(4 * i), 32'hC0 + 32'(i), 1, 32'h40);
    drive(0, 0, 0, 0, 0);
    chk("arst_pre_drain", 64'(mem_write_o), 64'(1));
    #2 rst_i = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_mem_write", 64'(mem_write_o), 64'(0));
    chk("arst_count", 64'(count_o), 64'(0));
    chk("arst_empty", 64'(empty_o), 64'(1));
    tick();
    rst_i = 1'b0;
    wlog.delete();
    repeat (4) step(0, 0, 0, 0, 0);
    chk("arst_no_writes", 64'(wlog.size()), 64'(0));

    // random traffic; the producer holds a store until it is accepted
    pv = 1'b0; pa = '0; pd = '0;
    repeat (3000) begin
      if (!pv && ($urandom_range(0, 1) == 1)) begin
        pv = 1'b1;
        pa = 32'($urandom_range(0, 7)) << 2;
        pd = $urandom;
      end
      lv = ($urandom_range(0, 2) == 0);
      la = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      drive(pv, pa, pd, lv, la);
      if (pv && exp_ready) pv = 1'b0;
      tick();
    end
    repeat (8) step(0, 0, 0, 0, 0);
    chk("final_count", 64'(count_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the EX/MEM pipeline register and the byte-addressed data memory.
- Accepts sw requests without stalling the pipeline.
- Drains one word per cycle into the data memory whenever the memory port is free.
- Resolves lw/sw ordering hazards against pending stores, either by store-to-load forwarding or by stalling the load.

Parameters:
- DEPTH, 4, number of pending store entries (power of two, >= 2)
- ADDR_W, 32, address width
- DATA_W, 32, store/load word width

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- st_valid_i  input  1  store request from the MEM stage
- st_addr_i  input  ADDR_W  store byte address (word-aligned)
- st_data_i  input  DATA_W  store data
- st_ready_o  output  1  buffer can accept a store this cycle
- ld_valid_i  input  1  load request from the MEM stage
- ld_addr_i  input  ADDR_W  load byte address (word-aligned)
- ld_hit_o  output  1  load satisfied from buffer (forwarding build only)
- ld_data_o  output  DATA_W  forwarded load data
- ld_stall_o  output  1  load must wait for drain (non-forwarding build only)
- mem_write_o  output  1  MemWrite to data memory
- mem_addr_o  output  ADDR_W  data memory address for drain
- mem_data_o  output  DATA_W  data memory write data for drain
- count_o  output  $clog2(DEPTH+1)  number of valid entries
- empty_o  output  1  count_o == 0

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr, data}; head (oldest) pointer, tail pointer, count register. Pointers wrap modulo DEPTH.
- Reset (async, rst_i=1): head=tail=count=0; entry contents cleared to 0. Resulting outputs: st_ready_o=1, empty_o=1, mem_write_o=0, mem_addr_o=0, mem_data_o=0, ld_hit_o=0, ld_data_o=0, ld_stall_o=0.
- Reset asserted mid-operation discards all pending stores; there is no partial drain.
- st_ready_o = (count != DEPTH). Not dependent on a same-cycle drain; no full-bypass.
- Enqueue: at the edge where st_valid_i && st_ready_o, write {st_addr_i, st_data_i} at tail and advance tail.
- st_valid_i while full: ignored. Producer holds the request until ready.
- Address match: compares addr[ADDR_W-1:2] only (word granularity). Bits [1:0] are stored and driven on mem_addr_o unchanged.
- match: ld_valid_i && any valid entry matches ld_addr_i. The youngest matching entry is selected (search from tail-1 back to head).
- A store enqueued in the same cycle as a load is not visible to that load; it becomes visible from the next cycle.
- Memory port free: mem_free = !ld_valid_i || ld_hit_o || ld_stall_o.
- Drain: mem_write_o = (count != 0) && mem_free, combinational. mem_addr_o/mem_data_o = head entry, always driven.
- Pop: at the edge where mem_write_o=1, advance head. Latency: data memory write completes in the cycle mem_write_o is high.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- Empty: mem_write_o=0 regardless of loads.
- Full with pop: st_ready_o stays 0 that cycle; the store is accepted next cycle.
- Minimum enqueue-to-drain latency: 1 cycle (entry is at head the cycle after enqueue if the buffer was empty).

Optional Feature:
- STORE_BUF_FWD_EN defined:
  - ld_hit_o = match; ld_data_o = data of the youngest matching entry (0 when no match).
  - ld_stall_o tied 0.
  - Hit loads do not use the memory, so drain proceeds in parallel.
- STORE_BUF_FWD_EN undefined:
  - ld_hit_o and ld_data_o tied 0; ld_stall_o = match.
  - While stalled, drain continues each cycle until no matching entry remains. ld_stall_o drops the cycle after the last matching entry pops, and the load then reads memory.

Test Plan:
- Reset then idle: rst_i pulse -> st_ready_o=1, empty_o=1, count_o=0, mem_write_o=0, all data outputs 0.
- Stores 0x10/0xAAAA0001, 0x14/0xAAAA0002 on back-to-back cycles with no loads -> mem_write_o high the cycle after each enqueue, memory receives both in order, count_o returns to 0.
- Hold ld_valid_i=1 (miss, addr 0x40) while filling 4 stores -> no drain, count_o=4, st_ready_o=0, fifth store held. Drop ld_valid_i -> 4 drains in FIFO order; fifth store accepted the cycle after the first pop.
- Forwarding on: stores 0x20/0x11111111 then 0x20/0x22222222, load 0x20 with ld_valid_i held -> ld_hit_o=1, ld_data_o=0x22222222, drain continues; load 0x22 also hits (word match).
- Forwarding off: same stores, load 0x20 -> ld_stall_o=1 for 2 drain cycles, then 0; memory holds 0x22222222 at 0x20.
- Async reset asserted with 3 pending entries mid-drain -> mem_write_o drops immediately, count_o=0, no further writes after reset release.
